// File: rtl/typing_round_sequencer.sv
// Typing game round sequencer: get-ready interval, timed play rounds,
// level advance on word count, and game-over / win endings.
module typing_round_sequencer #(
   parameter int TICKS_PER_SEC   = 150000000,
   parameter int READY_SECS      = 3,
   parameter int BASE_TIME       = 30,
   parameter int TIME_STEP       = 3,
   parameter int MIN_TIME        = 6,
   parameter int WORDS_PER_LEVEL = 5,
   parameter int MAX_LEVEL       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       word_done,
   output logic [3:0] level,
   output logic [7:0] secs_left,
   output logic [3:0] words_left,
   output logic       play_en,
   output logic       sec_tick,
   output logic       level_up,
   output logic       game_over,
   output logic       win,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READY     = 3'd1,
      S_PLAY      = 3'd2,
      S_LEVEL_UP  = 3'd3,
      S_GAME_OVER = 3'd4,
      S_WIN       = 3'd5
   } state_t;

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0] RDY = 8'(READY_SECS);
   localparam logic [3:0] WPL = 4'(WORDS_PER_LEVEL);
   localparam logic [3:0] MAXL = 4'(MAX_LEVEL);

   state_t        state_q, state_d;
   logic [3:0]    level_q, level_d;
   logic [7:0]    secs_q, secs_d;
   logic [3:0]    words_q, words_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic          lup_q, lup_d;
   logic          pen_q, pen_d;
   logic          go_q, go_d;
   logic          win_q, win_d;
   logic          run;
   logic          tick;

   // Play-time limit for a level, clamped at the floor; unsigned math
   // compares before subtracting so nothing goes negative.
   function automatic logic [7:0] limit_f(input logic [3:0] l);
      logic [15:0] red;
      red = (16'(l) - 16'd1) * 16'(TIME_STEP);
      if (16'(BASE_TIME) >= red + 16'(MIN_TIME))
         return 8'(16'(BASE_TIME) - red);
      else
         return 8'(MIN_TIME);
   endfunction

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      secs_d  = secs_q;
      words_d = words_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      lup_d   = 1'b0;

      run  = (state_q == S_READY || state_q == S_PLAY) && !pause;
      tick = run && (presc_q == TC);

      if (run)
         presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
         tick_d = 1'b1;
         if (secs_q != 8'd0)
            secs_d = secs_q - 8'd1;
      end

      case (state_q)
         S_IDLE, S_GAME_OVER, S_WIN: begin
            if (start) begin
               state_d = S_READY;
               level_d = 4'd1;
               secs_d  = RDY;
               words_d = WPL;
            end
         end
         S_READY: begin
            if (tick && secs_q == 8'd1) begin
               state_d = S_PLAY;
               secs_d  = limit_f(level_q);
               words_d = WPL;
            end
         end
         S_PLAY: begin
            if (tick && secs_q == 8'd1) begin
               state_d = S_GAME_OVER;
               secs_d  = 8'd0;
            end
            // A word landing with the final tick still clears the level.
            if (!pause && word_done && words_q != 4'd0) begin
               words_d = words_q - 4'd1;
               if (words_q == 4'd1) begin
                  if (level_q < MAXL) begin
                     state_d = S_LEVEL_UP;
                     lup_d   = 1'b1;
                  end else begin
                     state_d = S_WIN;
                  end
               end
            end
         end
         S_LEVEL_UP: begin
            state_d = S_READY;
            level_d = level_q + 4'd1;
            secs_d  = RDY;
            words_d = WPL;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)
         presc_d = '0;

      pen_d = (state_d == S_PLAY) && !pause;
      go_d  = (state_d == S_GAME_OVER);
      win_d = (state_d == S_WIN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         level_q <= 4'd1;
         secs_q  <= 8'd0;
         words_q <= WPL;
         presc_q <= '0;
         tick_q  <= 1'b0;
         lup_q   <= 1'b0;
         pen_q   <= 1'b0;
         go_q    <= 1'b0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         secs_q  <= secs_d;
         words_q <= words_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         lup_q   <= lup_d;
         pen_q   <= pen_d;
         go_q    <= go_d;
         win_q   <= win_d;
      end
   end

   assign state      = state_q;
   assign level      = level_q;
   assign secs_left  = secs_q;
   assign words_left = words_q;
   assign play_en    = pen_q;
   assign sec_tick   = tick_q;
   assign level_up   = lup_q;
   assign game_over  = go_q;
   assign win        = win_q;

endmodule
